// File: rtl/mux_sequencial_n_pkg.sv
// Shared defaults, button polarity and reset values for the sequential N-channel mux.
// Imported by button_conditioner and mux_sequencial_n.
package mux_seq_pkg;

    localparam int DEF_DATABUS_WIDTH   = 9;
    localparam int DEF_NUM_CHANNELS    = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 16;

    // The board button pulls low when pressed.
    localparam logic BTN_ACTIVE = 1'b0;

    // Reset values: the button path comes up "released"; sel and dataOut come up at zero.
    localparam logic SYNC_RST_VAL  = 1'b1;
    localparam logic LEVEL_RST_VAL = 1'b1;
    localparam logic PULSE_RST_VAL = 1'b0;

endpackage

// File: rtl/mux_sequencial_n_button_conditioner.sv
// Purpose: synchronise a raw active-low button, optionally debounce it (MUX_SEQ_DEBOUNCE_EN), emit one advance pulse per press.
// Latency: advance is high in the cycle after edge k+1 (or k+1+DEBOUNCE_CYCLES debounced) for a press first sampled at edge k.
// Backpressure: none; a held button never repeats, and a press already held at reset is ignored until released.
module button_conditioner
    import mux_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic advance
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic       sync_q1;
    logic       sync_q2;
    logic       level;
    logic       level_q;
    logic [1:0] prime;
    logic       armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= SYNC_RST_VAL;
            sync_q2 <= SYNC_RST_VAL;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

`ifdef MUX_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] db_cnt;
    logic             accepted;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            accepted <= LEVEL_RST_VAL;
        end else if (sync_q2 == accepted) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            accepted <= sync_q2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = accepted;
`else
    assign level = sync_q2;
`endif

    // The synchroniser output is only genuine two edges after reset; arm once it shows a released button,
    // so a press held across reset cannot masquerade as a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= LEVEL_RST_VAL;
            prime   <= '0;
            armed   <= 1'b0;
        end else begin
            level_q <= level;
            prime   <= {prime[0], 1'b1};
            if (prime[1] && (sync_q2 != BTN_ACTIVE)) begin
                armed <= 1'b1;
            end
        end
    end

    assign advance = armed && (level_q != BTN_ACTIVE) && (level == BTN_ACTIVE);

endmodule

// File: rtl/mux_sequencial_n.sv
// Purpose: N-channel round-robin mux; button press advances sel, loadSel forces it; debounce via MUX_SEQ_DEBOUNCE_EN.
// Latency: dataOut registered, 1 cycle from dataIn/sel; loadSel at edge k updates sel at k; button press 2 (+DEBOUNCE_CYCLES) edges.
// Backpressure: none; an out-of-range load drops itself and any simultaneous advance.
module mux_sequencial_n
    import mux_seq_pkg::*;
#(
    parameter  int DATABUS_WIDTH   = DEF_DATABUS_WIDTH,
    parameter  int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter  int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    localparam int SEL_WIDTH       = $clog2(NUM_CHANNELS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  toggleButton,
    input  logic                                  loadSel,
    input  logic [SEL_WIDTH-1:0]                  selIn,
    input  logic [NUM_CHANNELS*DATABUS_WIDTH-1:0] dataIn,
    output logic [DATABUS_WIDTH-1:0]              dataOut,
    output logic [SEL_WIDTH-1:0]                  sel,
    output logic                                  selChanged
);

    if (NUM_CHANNELS < 2) begin : g_bad_channels
        $error("NUM_CHANNELS must be at least 2");
    end

    logic                     advance;
    logic                     load_ok;
    logic [SEL_WIDTH-1:0]     sel_nxt;
    logic [DATABUS_WIDTH-1:0] chan [NUM_CHANNELS];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button_conditioner (
        .clk     (clk),
        .rst     (rst),
        .button  (toggleButton),
        .advance (advance)
    );

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        assign chan[i] = dataIn[i*DATABUS_WIDTH +: DATABUS_WIDTH];
    end

    // Extra bit so the range check is meaningful when NUM_CHANNELS is a power of two.
    assign load_ok = ({1'b0, selIn} < (SEL_WIDTH + 1)'(NUM_CHANNELS));

    always_comb begin
        sel_nxt = sel;
        if (loadSel) begin
            if (load_ok) begin
                sel_nxt = selIn;
            end
        end else if (advance) begin
            sel_nxt = (sel == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel        <= '0;
            selChanged <= PULSE_RST_VAL;
            dataOut    <= '0;
        end else begin
            sel        <= sel_nxt;
            selChanged <= (sel_nxt != sel);
            dataOut    <= chan[sel];
        end
    end

endmodule

// File: doc/mux_sequencial_n.md
# mux_sequencial_n

Parametrised N-channel sequential multiplexer: a push-button (active-low, acts on press) steps the selected channel round-robin through `NUM_CHANNELS` input buses, and a direct-load port forces any channel. The raw button input is synchronised and, optionally, debounced inside the block. The data output is registered. The block sits between the board button/switch inputs and the downstream display or datapath, replacing the two-input toggle mux.

## Interface
- `DATABUS_WIDTH`, 9: width of each channel bus and of `dataOut`.
- `NUM_CHANNELS`, 4: number of input channels, ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a button level is accepted, ≥1 (used only with debounce compiled in).
- `SEL_WIDTH` (localparam): `$clog2(NUM_CHANNELS)`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `toggleButton`  in  1  raw, asynchronous button; pressed = 0; a press advances the channel.
- `loadSel`  in  1  synchronous direct-select strobe.
- `selIn`  in  SEL_WIDTH  channel to load when `loadSel`=1.
- `dataIn`  in  NUM_CHANNELS*DATABUS_WIDTH  flattened channels; channel i occupies bits [i*DATABUS_WIDTH +: DATABUS_WIDTH].
- `dataOut`  out  DATABUS_WIDTH  registered selected channel.
- `sel`  out  SEL_WIDTH  current channel index.
- `selChanged`  out  1  one-cycle pulse, coincident with `sel` taking a new value.

## Operation
- Button path: two-flop synchroniser (reset to 1) → optional debounce → falling-edge detector produces a one-cycle `advance` pulse per accepted press. Release produces nothing.
- Debounce: accepted level resets to 1. Counter clears whenever the synchronised level equals the accepted level. The accepted level updates on the `DEBOUNCE_CYCLES`-th consecutive edge at which they differ. Any mismatch gap restarts the count.
- Select register `sel`, reset 0:
  - `loadSel`=1 with `selIn` < NUM_CHANNELS: `sel` ← `selIn`. Load wins over a simultaneous `advance`.
  - `loadSel`=1 with `selIn` ≥ NUM_CHANNELS: the load is ignored, and a simultaneous `advance` is also dropped; `sel` holds.
  - `advance` only: `sel` ← `sel`+1, wrapping NUM_CHANNELS-1 → 0 (also for non-power-of-2 NUM_CHANNELS).
- `selChanged` is 1 only when `sel` actually changes value. Loading the current index gives no pulse.
- Every clock edge: `dataOut` ← channel[`sel`] (current `sel`, pre-update value).
- Reset values: `dataOut`=0, `sel`=0, `selChanged`=0, sync flops=1, accepted level=1, debounce counter=0.
- Reset asserted mid-press: all state returns to reset values immediately. A button still held after release of `rst` does not produce an advance until it is released and pressed again.

## Timing
- Button low first sampled at edge k: synchronised level low after edge k+1.
- Debounce in: accepted level low at edge k+1+DEBOUNCE_CYCLES, `sel`/`selChanged` update at k+2+DEBOUNCE_CYCLES, `dataOut` shows the new channel at k+3+DEBOUNCE_CYCLES.
- Debounce out: `sel` at k+2, `dataOut` at k+3.
- `loadSel` sampled at edge k: `sel` at k, `dataOut` at k+1.
- `dataIn` to `dataOut` latency: 1 cycle. `dataIn` is synchronous to `clk`.
- Maximum advance rate: one step per press. A held button never auto-repeats.

## Configuration
- `MUX_SEQ_DEBOUNCE_EN` defined: debounce counter present as described; `DEBOUNCE_CYCLES` effective.
- Undefined: no counter. The synchronised level feeds the edge detector directly, and `DEBOUNCE_CYCLES` is ignored. All other behaviour is identical.

## Structure
- Package `mux_seq_pkg`:
  - default constants for `DATABUS_WIDTH`, `NUM_CHANNELS`, `DEBOUNCE_CYCLES`.
  - button-active level constant (0).
  - reset-value constants.
- Sub-module `button_conditioner`: contains the synchroniser, the debounce counter (macro-guarded) and the falling-edge pulse generator. It is parametrised by `DEBOUNCE_CYCLES` and outputs `advance`.
- The top level holds `sel`, the wrap logic, the load arbitration and the output register.

## Test plan
- Reset with channels 0..3 = 9'h011, 9'h022, 9'h033, 9'h044 → `sel`=0 and `dataOut`=0 during reset; `dataOut`=9'h011 one cycle after release.
- Debounce in, `DEBOUNCE_CYCLES`=16: four clean presses, each 40 cycles low then 40 high → `sel` steps 1, 2, 3, 0. Each step lands 18 cycles after the first low sample, with one `selChanged` pulse per press.
- Debounce in: 5-cycle low glitches repeated 10 times → `sel` unchanged, no `selChanged`.
- `loadSel`=1 with `selIn`=2 in the same cycle as an `advance` from `sel`=0 → `sel`=2 and one pulse. Then `selIn`=3 at NUM_CHANNELS=3 → ignored, `sel` stays 2.
- `rst` asserted mid-press, button held low through release → no advance. After release and a new press → `sel`=1.
- Debounce out, NUM_CHANNELS=3: press stream → `sel` 0→1→2→0, each update 2 cycles after the first low sample.
